random_range_sampler: RTL and testbench
=======================================

# random_range_sampler

Converts the free-running 16-bit pseudo-random stream from the LCG generator into an unbiased integer in the range `[0, bound-1]` on request. It sits directly downstream of the generator and upstream of game/control logic that needs dice-style values.
- Remainder comes from an iterative 16-step restoring divider.
- Samples that would bias the result are rejected and redrawn.
- Requests and results use valid/ready handshakes.

## Interface
Parameters:
- `BOUND_W`, default 8: width of `bound` and `out_value`. `bound`=0 encodes 2^BOUND_W. Legal range 1..16.
- `MAX_RETRY`, default 7: number of rejections after which the next sample is accepted unconditionally.

Ports:
- `clk` — in, 1 — clock.
- `rst` — in, 1 — reset, asynchronous, active-high.
- `random_in` — in, 16 — current LCG output; changes every clock.
- `req_valid` — in, 1 — request present.
- `req_ready` — out, 1 — block idle and able to accept a request.
- `bound` — in, BOUND_W — exclusive upper limit; sampled on request handshake.
- `out_valid` — out, 1 — result available.
- `out_ready` — in, 1 — consumer takes result.
- `out_value` — out, BOUND_W — result, always < effective bound.
- `out_biased` — out, 1 — result was forced by retry exhaustion.

## Operation
- States: IDLE, DIV, CHECK, DONE.
- `req_ready` = (state==IDLE), driven combinationally.
- **IDLE:**
  - Trigger: `req_valid && req_ready`.
  - Latch effective bound B (17-bit; 0 maps to 2^BOUND_W).
  - Latch D = `random_in`; clear remainder R and step counter; clear retry count.
  - Go to DIV.
- **DIV:** one restoring-division step per clock.
  - R = {R,D[msb]}; if R ≥ B then subtract B; shift D.
  - After 16 steps R = D mod B; go to CHECK.
- **CHECK:** accept iff `D + (B − R) ≤ 65536`, evaluated in 17+ bits. This is equivalent to D < B·floor(65536/B).
  - Accept: `out_value` = R[BOUND_W-1:0]. `out_biased` = 1 only if forced. Go to DONE.
  - Reject with retry count < MAX_RETRY: increment retry count, re-latch D = `random_in` in the same edge, go to DIV.
  - Reject with retry count == MAX_RETRY: accept anyway with `out_biased`=1.
- **DONE:** `out_valid`=1. `out_value` and `out_biased` are held stable until `out_ready`, then go to IDLE.
- `random_in` is ignored outside the IDLE handshake edge and the CHECK re-latch edge.
- B = 1 always yields 0 and is always accepted. Any power-of-two B is never rejected.
- Reset (asynchronous, any state, including mid-division or DONE):
  - State → IDLE.
  - `out_valid`=0, `out_value`=0, `out_biased`=0.
  - Retry count and divider registers cleared.
  - `req_ready`=1 once reset is released.

## Timing
- Request handshake at edge E0. DIV steps occupy E1..E16. CHECK is evaluated at E17.
- `out_valid` is high from E17 when the first sample is accepted, giving 17-cycle latency.
- Each rejection adds 17 cycles. Worst case is 17·(MAX_RETRY+1) cycles.
- Output handshake at edge Ek (`out_valid && out_ready`):
  - `out_valid` falls after Ek.
  - `req_ready` rises after Ek.
  - The next request can be accepted at Ek+1.
- There is no back-to-back overlap: `req_ready` is 0 from the cycle after E0 through DONE.
- `out_ready` asserted early, before `out_valid`, has no effect.
- `req_valid` held while busy is ignored, not queued.

## Configuration
- Macro: `RANGE_SAMPLER_STATS_EN`.
- **Defined:** adds output `reject_count` [15:0].
  - Increments by 1 on every rejection, whether it leads to a retry or a forced accept.
  - Saturates at 0xFFFF.
  - Cleared only by `rst`.
- **Undefined:** port and counter absent; all other behaviour identical.

## Test plan
- Bound 6, `random_in`=0xACE1 at handshake → `out_value`=1, `out_biased`=0, `out_valid` rises exactly 17 cycles after the handshake.
- Bound 100:
  - `random_in`=0xFFFF at handshake → reject.
  - `random_in`=0x0064 at the CHECK edge → `out_value`=0 at 34 cycles.
  - With stats enabled, `reject_count`=1.
- MAX_RETRY=0, bound 100, `random_in`=0xFFFF → `out_value`=35, `out_biased`=1, 17 cycles.
- Bound 0 (BOUND_W=8), `random_in`=0xACE1 → `out_value`=0xE1, never rejected. Bound 1 → 0.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_value` is stable and `req_ready`=0. Then pulse `out_ready` → `req_ready`=1 on the next cycle.
- Assert `rst` during step 8 of DIV → `out_valid`=0, `out_value`=0, `req_ready`=1. A fresh request then completes normally.

Source files
------------

// File: rtl/random_range_sampler.sv
// Unbiased range sampler: reduces a 16-bit LCG sample modulo a bound with rejection/redraw.
// Optional reject statistics output enabled by defining RANGE_SAMPLER_STATS_EN.
module random_range_sampler #(
    parameter int BOUND_W   = 8,
    parameter int MAX_RETRY = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        random_in,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [BOUND_W-1:0] bound,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BOUND_W-1:0] out_value,
    output logic               out_biased
`ifdef RANGE_SAMPLER_STATS_EN
    ,
    output logic [15:0]        reject_count
`endif
);

    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        CHECK,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [16:0]        r_b;
    logic [15:0]        r_d;
    logic [15:0]        r_shift;
    logic [16:0]        r_rem;
    logic [3:0]         r_step;
    logic [RW-1:0]      r_retry;
    logic [BOUND_W-1:0] r_value;
    logic               r_biased;

    logic [16:0]        w_b_eff;
    logic [16:0]        w_trial;
    logic [16:0]        w_rem_next;
    logic [17:0]        w_sum;
    logic               w_accept;
    logic               w_exhausted;

    assign w_b_eff     = (bound == '0) ? (17'd1 << BOUND_W) : 17'(bound);
    assign w_trial     = {r_rem[15:0], r_shift[15]};
    assign w_rem_next  = (w_trial >= r_b) ? (w_trial - r_b) : w_trial;
    // D + (B - R) <= 2^16 rejects exactly the samples from the partial top bucket.
    assign w_sum       = 18'(r_d) + 18'(r_b - r_rem);
    assign w_accept    = (w_sum <= 18'd65536);
    assign w_exhausted = (r_retry == RW'(MAX_RETRY));

    assign req_ready  = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_value  = r_value;
    assign out_biased = r_biased;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)              w_state_next = DIV;
            DIV:     if (r_step == 4'd15)        w_state_next = CHECK;
            CHECK:   if (w_accept || w_exhausted) w_state_next = DONE;
                     else                        w_state_next = DIV;
            DONE:    if (out_ready)              w_state_next = IDLE;
            default:                             w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b      <= '0;
            r_d      <= '0;
            r_shift  <= '0;
            r_rem    <= '0;
            r_step   <= '0;
            r_retry  <= '0;
            r_value  <= '0;
            r_biased <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_b     <= w_b_eff;
                        r_d     <= random_in;
                        r_shift <= random_in;
                        r_rem   <= '0;
                        r_step  <= '0;
                        r_retry <= '0;
                    end
                end
                DIV: begin
                    r_rem   <= w_rem_next;
                    r_shift <= {r_shift[14:0], 1'b0};
                    r_step  <= r_step + 4'd1;
                end
                CHECK: begin
                    if (w_accept || w_exhausted) begin
                        r_value  <= r_rem[BOUND_W-1:0];
                        r_biased <= ~w_accept;
                    end else begin
                        r_retry <= r_retry + RW'(1);
                        r_d     <= random_in;
                        r_shift <= random_in;
                        r_rem   <= '0;
                        r_step  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RANGE_SAMPLER_STATS_EN
    logic [15:0] r_rejects;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rejects <= '0;
        else if (r_state == CHECK && !w_accept && r_rejects != 16'hFFFF)
            r_rejects <= r_rejects + 16'd1;
    end

    assign reject_count = r_rejects;
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// Directed bench for random_range_sampler: default instance plus a MAX_RETRY=0 instance,
// expected results queued at request time and compared when out_valid appears.
module tb_random_range_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] random_in;
    logic        req_valid, req_valid0;
    logic        req_ready, req_ready0;
    logic [7:0]  bound;
    logic        out_valid, out_valid0;
    logic        out_ready;
    logic [7:0]  out_value, out_value0;
    logic        out_biased, out_biased0;
`ifdef RANGE_SAMPLER_STATS_EN
    logic [15:0] reject_count, reject_count0;
`endif

    random_range_sampler #(.BOUND_W(8), .MAX_RETRY(7)) dut (
        .clk(clk), .rst(rst), .random_in(random_in),
        .req_valid(req_valid), .req_ready(req_ready), .bound(bound),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_biased(out_biased)
`ifdef RANGE_SAMPLER_STATS_EN
        , .reject_count(reject_count)
`endif
    );

    random_range_sampler #(.BOUND_W(8), .MAX_RETRY(0)) dut0 (
        .clk(clk), .rst(rst), .random_in(random_in),
        .req_valid(req_valid0), .req_ready(req_ready0), .bound(bound),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_value(out_value0), .out_biased(out_biased0)
`ifdef RANGE_SAMPLER_STATS_EN
        , .reject_count(reject_count0)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] value;
        logic       biased;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // sel=1 drives the MAX_RETRY=0 instance; rin2 is presented at every CHECK edge.
    task automatic run_req(input bit sel, input logic [7:0] b, input logic [15:0] rin,
                           input logic [15:0] rin2, input int hold, input exp_t e);
        exp_t got;
        int   n;
        sb.push_back(e);
        @(negedge clk);
        check("req_ready_idle", sel ? req_ready0 : req_ready, 1);
        bound     = b;
        random_in = rin;
        if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        bound = ~b;
        while (n < 300) begin
            random_in = (n % 17 == 16) ? rin2 : 16'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sel ? out_valid0 : out_valid) break;
            check("busy_ready_low", sel ? req_ready0 : req_ready, 0);
        end
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        got = sb.pop_front();
        check("out_valid", sel ? out_valid0 : out_valid, 1);
        check("latency", n, got.lat);
        check("out_value", sel ? out_value0 : out_value, got.value);
        check("out_biased", sel ? out_biased0 : out_biased, got.biased);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_value", sel ? out_value0 : out_value, got.value);
            check("hold_req_ready", sel ? req_ready0 : req_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", sel ? out_valid0 : out_valid, 0);
        check("ready_rise", sel ? req_ready0 : req_ready, 1);
    endtask

    initial begin
        logic [15:0] r, r2;
        logic [8:0]  bb;
        logic [16:0] rem;
        rst        = 1'b1;
        random_in  = 16'h0;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        bound      = 8'd0;
        out_ready  = 1'b0;
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_biased", out_biased, 0);
        @(negedge clk);
        rst = 1'b0;

        // 0xACE1 mod 6 = 1, accepted first try; out_ready held off for 10 cycles
        run_req(1'b0, 8'd6, 16'hACE1, 16'h0000, 10, '{8'd1, 1'b0, 17});
        // 0xFFFF rejected for bound 100, redraw 0x0064 -> 0
        run_req(1'b0, 8'd100, 16'hFFFF, 16'h0064, 0, '{8'd0, 1'b0, 34});
`ifdef RANGE_SAMPLER_STATS_EN
        check("reject_count", reject_count, 1);
`endif
        // bound 0 encodes 256; never rejected
        run_req(1'b0, 8'd0, 16'hACE1, 16'hFFFF, 0, '{8'hE1, 1'b0, 17});

        // reset during step 8 of the divider
        @(negedge clk);
        bound     = 8'd6;
        random_in = 16'h1234;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_value", out_value, 0);
        check("midrst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("postrst_req_ready", req_ready, 1);
        check("postrst_out_valid", out_valid, 0);

        // bound 1 -> always 0
        run_req(1'b0, 8'd1, 16'hFFFF, 16'hFFFF, 0, '{8'd0, 1'b0, 17});
        // no retries allowed: forced accept of 65535 mod 100 = 35
        run_req(1'b1, 8'd100, 16'hFFFF, 16'hFFFF, 0, '{8'd35, 1'b1, 17});
`ifdef RANGE_SAMPLER_STATS_EN
        check("reject_count0", reject_count0, 1);
`endif

        // model-driven cases; the redraw value is small so it is always accepted
        for (int k = 0; k < 6; k++) begin
            bb = 9'($urandom_range(2, 255));
            r  = (k % 2 == 0) ? 16'($urandom) : 16'($urandom_range(65280, 65535));
            r2 = 16'($urandom_range(0, 1000));
            rem = 17'(r) % 17'(bb);
            if (17'(r) + (17'(bb) - rem) <= 17'd65536)
                run_req(1'b0, bb[7:0], r, r2, 0, '{rem[7:0], 1'b0, 17});
            else
                run_req(1'b0, bb[7:0], r, r2, 0,
                        '{8'(17'(r2) % 17'(bb)), 1'b0, 34});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
